// File: rtl/march_pkg.sv
// Shared types and widths for the invader march stepper.
package march_pkg;
   localparam int OFFSET_X_W = 10;
   localparam int OFFSET_Y_W = 9;
   localparam int ALIVE_W    = 6;

   typedef enum logic [1:0] {IDLE, MARCH_R, MARCH_L, LANDED} march_state_t;
endpackage

// File: rtl/march_tick_skipper.sv
// Counts accepted ticks between march steps; MARCH_SPEEDUP_EN makes the
// reload track alive_count so the fleet speeds up as invaders die.
module march_tick_skipper
   import march_pkg::*;
#(
   parameter int MAX_SKIP = 7
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               tick_en,
   input  logic               clear,
   input  logic [ALIVE_W-1:0] alive_count,
   output logic               step_en
);
   localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

   logic [SKIP_W-1:0] r_skip;
   logic [SKIP_W-1:0] w_reload;

`ifdef MARCH_SPEEDUP_EN
   logic [ALIVE_W-1:0] w_div;
   assign w_div    = alive_count >> 3;
   assign w_reload = (w_div > ALIVE_W'(MAX_SKIP)) ? SKIP_W'(MAX_SKIP) : SKIP_W'(w_div);
`else
   logic w_unused_alive;
   assign w_unused_alive = ^alive_count;
   assign w_reload       = SKIP_W'(MAX_SKIP);
`endif

   assign step_en = tick_en && (r_skip == '0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_skip <= '0;
      end else if (clear) begin
         r_skip <= '0;
      end else if (tick_en) begin
         if (r_skip != '0) r_skip <= r_skip - 1'b1;
         else              r_skip <= w_reload;
      end
   end
endmodule

// File: rtl/invader_march_stepper.sv
// Fleet march FSM and offset registers; optional MARCH_SPEEDUP_EN lives in
// march_tick_skipper.
module invader_march_stepper
   import march_pkg::*;
#(
   parameter logic [OFFSET_X_W-1:0] X_MAX    = 10'd256,
   parameter int                    STEP_X   = 8,
   parameter int                    STEP_Y   = 16,
   parameter logic [OFFSET_Y_W-1:0] Y_LAND   = 9'd192,
   parameter int                    MAX_SKIP = 7
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  tick,
   input  logic                  start,
   input  logic                  freeze,
   input  logic [ALIVE_W-1:0]    alive_count,
   output logic [OFFSET_X_W-1:0] offset_x,
   output logic [OFFSET_Y_W-1:0] offset_y,
   output logic                  step_pulse,
   output logic                  landed,
   output logic                  cleared
);
   march_state_t          r_state;
   logic [OFFSET_X_W-1:0] r_off_x;
   logic [OFFSET_Y_W-1:0] r_off_y;
   logic                  r_step;
   logic                  r_cleared;

   logic                  w_march;
   logic                  w_clear;
   logic                  w_tick_en;
   logic                  w_step_en;
   logic [OFFSET_X_W:0]   w_x_add;
   logic [OFFSET_Y_W:0]   w_y_add;
   logic                  w_x_fits;
   logic                  w_land;

   // Priority start > clear > freeze > tick is folded into the enables.
   assign w_march   = (r_state == MARCH_R) || (r_state == MARCH_L);
   assign w_clear   = w_march && (alive_count == '0) && !start;
   assign w_tick_en = tick && !freeze && w_march && !start && !w_clear;

   assign w_x_add  = {1'b0, r_off_x} + (OFFSET_X_W+1)'(STEP_X);
   assign w_y_add  = {1'b0, r_off_y} + (OFFSET_Y_W+1)'(STEP_Y);
   assign w_x_fits = (w_x_add <= {1'b0, X_MAX});
   assign w_land   = (w_y_add >= {1'b0, Y_LAND});

   march_tick_skipper #(.MAX_SKIP(MAX_SKIP)) u_skip (
      .clk         (clk),
      .resetN      (resetN),
      .tick_en     (w_tick_en),
      .clear       (start),
      .alive_count (alive_count),
      .step_en     (w_step_en)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= IDLE;
         r_off_x   <= '0;
         r_off_y   <= '0;
         r_step    <= 1'b0;
         r_cleared <= 1'b0;
      end else begin
         r_step    <= 1'b0;
         r_cleared <= 1'b0;
         if (start) begin
            r_state <= MARCH_R;
            r_off_x <= '0;
            r_off_y <= '0;
         end else if (w_clear) begin
            r_state   <= IDLE;
            r_cleared <= 1'b1;
         end else if (w_step_en) begin
            r_step <= 1'b1;
            case (r_state)
               MARCH_R: begin
                  if (w_x_fits) begin
                     r_off_x <= w_x_add[OFFSET_X_W-1:0];
                  end else begin
                     r_off_y <= w_y_add[OFFSET_Y_W-1:0];
                     r_state <= w_land ? LANDED : MARCH_L;
                  end
               end
               MARCH_L: begin
                  if (r_off_x >= OFFSET_X_W'(STEP_X)) begin
                     r_off_x <= r_off_x - OFFSET_X_W'(STEP_X);
                  end else begin
                     r_off_y <= w_y_add[OFFSET_Y_W-1:0];
                     r_state <= w_land ? LANDED : MARCH_R;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign offset_x   = r_off_x;
   assign offset_y   = r_off_y;
   assign step_pulse = r_step;
   assign cleared    = r_cleared;
   assign landed     = (r_state == LANDED);
endmodule

// File: tb/tb_invader_march_stepper.sv
// Directed bench with a behavioural fleet model checked every cycle.
module tb_invader_march_stepper;
   localparam int XMAX = 32;
   localparam int YLAND = 32;
`ifdef MARCH_SPEEDUP_EN
   localparam int RL7 = 0;   // reload seen with alive_count=7
`else
   localparam int RL7 = 7;
`endif

   logic       clk = 0;
   logic       resetN = 0;
   logic       tick = 0, start = 0, freeze = 0;
   logic [5:0] alive_count = 6'd40;
   logic [9:0] offset_x;
   logic [8:0] offset_y;
   logic       step_pulse, landed, cleared;

   int errs = 0, checks = 0;

   invader_march_stepper #(
      .X_MAX(10'd32), .STEP_X(8), .STEP_Y(16), .Y_LAND(9'd32), .MAX_SKIP(7)
   ) dut (
      .clk(clk), .resetN(resetN), .tick(tick), .start(start), .freeze(freeze),
      .alive_count(alive_count), .offset_x(offset_x), .offset_y(offset_y),
      .step_pulse(step_pulse), .landed(landed), .cleared(cleared)
   );

   always #5 clk = ~clk;

   // Model: 0 idle, 1 right, 2 left, 3 landed
   int m_state = 0, m_x = 0, m_y = 0, m_skip = 0, m_step = 0, m_clr = 0;

   function automatic int reload(int alive);
`ifdef MARCH_SPEEDUP_EN
      return (alive / 8 > 7) ? 7 : alive / 8;
`else
      return 7;
`endif
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_state = 0; m_x = 0; m_y = 0; m_skip = 0; m_step = 0; m_clr = 0;
      end else begin
         m_step = 0; m_clr = 0;
         if (start) begin
            m_state = 1; m_x = 0; m_y = 0; m_skip = 0;
         end else if ((m_state == 1 || m_state == 2) && alive_count == 0) begin
            m_state = 0; m_clr = 1;
         end else if ((m_state == 1 || m_state == 2) && tick && !freeze) begin
            if (m_skip > 0) m_skip--;
            else begin
               m_skip = reload(int'(alive_count));
               m_step = 1;
               if (m_state == 1 && m_x + 8 <= XMAX) m_x += 8;
               else if (m_state == 2 && m_x >= 8) m_x -= 8;
               else begin
                  m_y += 16;
                  m_state = (m_y >= YLAND) ? 3 : (m_state == 1 ? 2 : 1);
               end
            end
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("x", int'(offset_x), m_x);
      chk("y", int'(offset_y), m_y);
      chk("step", int'(step_pulse), m_step);
      chk("landed", int'(landed), int'(m_state == 3));
      chk("cleared", int'(cleared), m_clr);
      chk("step_and_clear", int'(step_pulse & cleared), 0);
   endtask

   // One clock: check model at negedge, drive, release strobes after edge.
   task automatic cyc(logic t, logic s);
      @(negedge clk);
      compare();
      tick = t; start = s;
      @(posedge clk); #1;
      tick = 0; start = 0;
   endtask

   task automatic steps(int k);
      for (int i = 0; i < k * (RL7 + 1); i++) cyc(1, 0);
   endtask

   int npulse;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", int'(offset_x), 0);
      chk("rst_y", int'(offset_y), 0);
      chk("rst_landed", int'(landed), 0);
      @(negedge clk); resetN = 1;
      cyc(1, 0);                       // ignored in IDLE

      // alive=40: first tick steps, next two back-to-back ticks skip
      alive_count = 6'd40;
      cyc(0, 1);
      cyc(1, 0);
      chk("t1_x", int'(offset_x), 8);
      chk("t1_step", int'(step_pulse), 1);
      cyc(1, 0); cyc(1, 0);
      chk("t3_x", int'(offset_x), 8);
      chk("t3_step", int'(step_pulse), 0);

      // right march to the edge, drop, then left
      alive_count = 6'd7;
      cyc(0, 1);
      steps(4);
      chk("edge_x", int'(offset_x), 32);
      steps(1);
      chk("drop_y", int'(offset_y), 16);
      chk("drop_x", int'(offset_x), 32);
      steps(1);
      chk("left_x", int'(offset_x), 24);

      // freeze holds everything
      freeze = 1;
      for (int i = 0; i < 5; i++) cyc(1, 0);
      chk("frz_x", int'(offset_x), 24);
      freeze = 0;
      cyc(1, 0);
      chk("unfrz_x", int'(offset_x), 16);
      chk("unfrz_step", int'(step_pulse), 1);
      for (int i = 0; i < RL7; i++) cyc(1, 0);

      // second drop lands
      steps(2);
      cyc(1, 0);
      chk("land_y", int'(offset_y), 32);
      chk("land_lvl", int'(landed), 1);
      chk("land_step", int'(step_pulse), 1);
      for (int i = 0; i < 16; i++) cyc(1, 0);
      chk("landed_hold_x", int'(offset_x), 0);
      cyc(0, 1);
      chk("restart_x", int'(offset_x), 0);
      chk("restart_y", int'(offset_y), 0);
      chk("restart_landed", int'(landed), 0);

      // clear coincident with a step tick
      steps(2);
      alive_count = 6'd0;
      cyc(1, 0);
      chk("clr_pulse", int'(cleared), 1);
      chk("clr_step", int'(step_pulse), 0);
      chk("clr_x", int'(offset_x), 16);
      alive_count = 6'd7;
      cyc(1, 0);
      chk("clr_once", int'(cleared), 0);
      chk("idle_x", int'(offset_x), 16);
      cyc(1, 0);

      // async reset mid-wave
      cyc(0, 1);
      steps(3);
      chk("pre_rst_x", int'(offset_x), 24);
      @(negedge clk); #2 resetN = 0;
      #1;
      chk("arst_x", int'(offset_x), 0);
      chk("arst_y", int'(offset_y), 0);
      @(negedge clk); resetN = 1;
      for (int i = 0; i < 4; i++) cyc(1, 0);
      chk("post_rst_x", int'(offset_x), 0);
      cyc(0, 1);
      cyc(1, 0);
      chk("post_start_x", int'(offset_x), 8);
      for (int i = 0; i < RL7; i++) cyc(1, 0);

      // step rate with alive=7
      npulse = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0);
         npulse += int'(step_pulse);
      end
      chk("rate_pulses", npulse, 16 / (RL7 + 1));
      cyc(0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/invader_march_stepper.md
# invader_march_stepper

Consumer of the periodic terminal-count strobe produced by the game's down-counter tick generators. Each accepted strobe advances the invader fleet one march step: horizontal moves with edge reversal and a drop row at each edge, and fewer accepted strobes between steps as invaders die. Outputs a registered fleet offset for the object-drawing logic, plus step, landed and cleared status for the game controller.

## Interface
Parameters:
- X_MAX, 10'd256: largest legal horizontal offset; a step that would exceed it triggers drop-and-reverse.
- STEP_X, 8: horizontal pixels per step.
- STEP_Y, 16: vertical pixels per drop.
- Y_LAND, 9'd192: vertical offset at or beyond which the fleet has landed.
- MAX_SKIP, 7: largest number of strobes skipped between steps.

Ports:
- clk, in, 1: system clock, single domain.
- resetN, in, 1: reset, asynchronous, active-low.
- tick, in, 1: one-cycle strobe from the tick generator (its terminal count).
- start, in, 1: one-cycle strobe that begins a wave.
- freeze, in, 1: level signal; while high, ticks are ignored and all state is held.
- alive_count, in, 6: number of invaders still alive, 0..63.
- offset_x, out, 10: fleet horizontal offset.
- offset_y, out, 9: fleet vertical offset.
- step_pulse, out, 1: high for one cycle when the offsets change.
- landed, out, 1: level signal, high while in LANDED.
- cleared, out, 1: one-cycle pulse when the wave ends because alive_count reached 0.

## Operation
- States: IDLE, MARCH_R, MARCH_L, LANDED.
- Reset values: IDLE, offset_x=0, offset_y=0, skip_cnt=0, all status outputs 0.
- IDLE:
  - start loads offset_x=0, offset_y=0, skip_cnt=0 and enters MARCH_R.
  - tick is ignored.
- Accepted tick: tick=1, freeze=0, and state is MARCH_R or MARCH_L.
  - If skip_cnt≠0: decrement skip_cnt, no step.
  - If skip_cnt=0: perform a step and reload skip_cnt with the reload value.
- Reload value:
  - With the speedup feature: min(alive_count>>3, MAX_SKIP).
  - Without it: MAX_SKIP.
- Step in MARCH_R:
  - If offset_x+STEP_X ≤ X_MAX: offset_x += STEP_X.
  - Otherwise: offset_y += STEP_Y, offset_x unchanged, go to MARCH_L.
- Step in MARCH_L:
  - If offset_x ≥ STEP_X: offset_x -= STEP_X.
  - Otherwise: offset_y += STEP_Y, go to MARCH_R.
- Arithmetic:
  - Additions are evaluated at 11 bits (x) and 10 bits (y), so they never wrap.
  - offset_x stays within 0..X_MAX.
- Landing: if a drop makes offset_y ≥ Y_LAND, go to LANDED instead of reversing.
- LANDED holds the offsets; only start leaves it (restarts the wave as from IDLE).
- Clear: alive_count=0 in either MARCH state returns to IDLE with a one-cycle cleared pulse. Offsets are held and no step occurs that cycle.
- Priority, highest first: start, clear, freeze, tick.
  - start while marching restarts the wave.
- freeze=1 holds skip_cnt, state and offsets, and drops any coincident tick.
- Ticks arriving in back-to-back cycles are each handled independently.

## Timing
- Latency: tick sampled at edge N; new offsets and step_pulse=1 during cycle N+1.
- All outputs are registered; no combinational path from input to output.
- cleared and step_pulse never assert in the same cycle.
- landed rises in the same cycle as the step_pulse of the landing drop.
- resetN low mid-wave forces reset values immediately (asynchronous); the first step after start follows the first accepted tick.

## Configuration
- MARCH_SPEEDUP_EN:
  - Defined: reload value derived from alive_count as above, so the fleet speeds up as invaders die.
  - Undefined: constant MAX_SKIP reload, alive_count is used only for clear detection, and steps occur every MAX_SKIP+1 accepted ticks.

## Structure
- Package march_pkg holds:
  - the state enum march_state_t (IDLE, MARCH_R, MARCH_L, LANDED);
  - width constants OFFSET_X_W=10, OFFSET_Y_W=9, ALIVE_W=6.
- Sub-module march_tick_skipper owns skip_cnt and the reload value.
  - Inputs: clk, resetN, tick_en, clear, alive_count.
  - Output: step_en.
- Top level holds the FSM and the offset registers.

## Test plan
- Reset, start, alive_count=40, 3 ticks: step_pulse after tick 1 with offset_x=8 and skip_cnt reloaded to 5. Ticks 2–3 cause no step.
- alive_count=7 (reload 0), X_MAX=16: ticks give offset_x=8, then 16. Next tick: offset_y=16, state MARCH_L. Next: offset_x=8.
- Y_LAND=32, alive_count=7, march to the second drop: offset_y=32, landed=1, later ticks change nothing. start restores offsets 0,0 and MARCH_R.
- freeze=1 for 5 ticks: no step_pulse, offsets and skip_cnt unchanged. freeze=0 then one tick: step resumes.
- alive_count→0 coincident with a step tick: cleared=1 for one cycle, no step_pulse, state IDLE, offsets held.
- resetN pulsed low mid-wave at offset_x=24: outputs 0 immediately; ticks ignored until start.
- Without MARCH_SPEEDUP_EN, alive_count=7: steps only every 8th accepted tick.
